// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the configuration chain serial master.
package cfg_chain_pkg;

    localparam int unsigned SIZESRSTAT_DEF = 88;
    localparam int unsigned SIZESRDYN_DEF  = 16;
    localparam int unsigned FRAME_LEN_DEF  = SIZESRSTAT_DEF + SIZESRDYN_DEF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        DONE_ST
    } state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) result++;
        return result;
    endfunction

endpackage

// File: rtl/sdo_sync.sv
// Two-flop synchronizer for the asynchronous SDO return from the chain tail.
module sdo_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Two-stage resync, cleared to 0 together with the chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/config_shift_master.sv
// Serial master that loads the static+dynamic config chain MSB-first over
// SEL/SCLK/SDI, captures the old chain contents from SDO and flags a readback
// mismatch against the previously sent frame.
module config_shift_master
    import cfg_chain_pkg::*;
#(
    parameter int unsigned SIZESRSTAT = SIZESRSTAT_DEF,
    parameter int unsigned SIZESRDYN  = SIZESRDYN_DEF,
    parameter int unsigned CLKDIV     = 4
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            START,
    input  logic [SIZESRSTAT-1:0]           STATCNF_IN,
    input  logic [SIZESRDYN-1:0]            DYNCNF_IN,
    output logic                            BUSY,
    output logic                            DONE,
    output logic                            SCLK,
    output logic                            SEL,
    output logic                            SDI,
    input  logic                            SDO,
    output logic [SIZESRSTAT+SIZESRDYN-1:0] RDBK,
    output logic                            MISMATCH
);

    localparam int unsigned FRAME_LEN = SIZESRSTAT + SIZESRDYN;
    localparam int unsigned CNT_W     = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);
    localparam int unsigned DIV_W     = (clog2(CLKDIV) < 1) ? 1 : clog2(CLKDIV);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);

    state_e                 state_q;
    logic [DIV_W-1:0]       div_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [FRAME_LEN-1:0]   frame_q;
    logic [FRAME_LEN-1:0]   rx_q;
    logic [FRAME_LEN-1:0]   prev_q;
    logic [FRAME_LEN-1:0]   rdbk_q;
    logic                   mism_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   sclk_q;
    logic                   sel_q;
    logic                   sdi_q;
    logic                   sdo_s;
    logic                   div_last;

    sdo_sync u_sdo_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (SDO),
        .q_o    (sdo_s)
    );

    assign div_last = (div_q == DIV_LAST);

    // Frame sequencer: divider, bit counter, frame/readback registers and
    // pin outputs. Pin outputs are flopped from the state held during the
    // current cycle, so every pin trails its state by one CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            rx_q      <= '0;
            prev_q    <= '0;
            rdbk_q    <= '0;
            mism_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sel_q     <= 1'b0;
            sdi_q     <= 1'b0;
        end else begin
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == DONE_ST);
            sel_q  <= state_q inside {SETUP, SHIFT_LO, SHIFT_HI, HOLD};
            sclk_q <= (state_q == SHIFT_HI);

            case (state_q)
                SETUP:          sdi_q <= frame_q[FRAME_LEN-1];
                SHIFT_LO:       sdi_q <= frame_q[bit_cnt_q];
                SHIFT_HI, HOLD: sdi_q <= sdi_q;
                default:        sdi_q <= 1'b0;
            endcase

            div_q <= (div_last || state_q == IDLE || state_q == DONE_ST) ? '0 : div_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (START) begin
                        frame_q   <= {STATCNF_IN, DYNCNF_IN};
                        bit_cnt_q <= LAST_BIT;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_last) state_q <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_last) begin
                        rx_q[bit_cnt_q] <= sdo_s;
                        state_q         <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (div_last) begin
                        if (bit_cnt_q == '0) begin
                            state_q <= HOLD;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                            state_q   <= SHIFT_LO;
                        end
                    end
                end
                HOLD: begin
                    if (div_last) state_q <= DONE_ST;
                end
                DONE_ST: begin
                    rdbk_q  <= rx_q;
                    mism_q  <= (rx_q != prev_q);
                    prev_q  <= frame_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign SCLK     = sclk_q;
    assign SEL      = sel_q;
    assign SDI      = sdi_q;
    assign RDBK     = rdbk_q;
    assign MISMATCH = mism_q;

endmodule

// File: tb/tb_config_shift_master.sv
// Self-checking bench: a behavioural 104-bit chain (shift on SCLK rise, latch
// on SEL fall, cleared by RST_N) feeds SDO; a frame-level scoreboard predicts
// readback, mismatch, latency and latched contents.
module tb_config_shift_master;

    localparam int unsigned FL = 104;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          start6 = 1'b0;
    logic [87:0]   stat = '0;
    logic [15:0]   dyn = '0;
    logic          busy, done, sclk, sel, sdi, sdo, mism;
    logic [FL-1:0] rdbk;
    logic          busy6, done6, sclk6, sel6, sdi6, mism6;
    logic [FL-1:0] rdbk6;

    logic [FL-1:0] chain = '0;
    logic [FL-1:0] latched = '0;
    logic [FL-1:0] flip_mask = '0;
    logic          flip_stb = 1'b0;
    int unsigned   sclk_rises = 0;
    int unsigned   done_rises = 0;

    // Frame-level scoreboard state.
    logic [FL-1:0] exp_chain = '0;
    logic [FL-1:0] exp_prev = '0;
    logic [FL-1:0] exp_last_rdbk = '0;
    logic          exp_last_mism = 1'b0;

    int unsigned   n_checks = 0;
    int unsigned   n_fail = 0;

    always #5 clk = ~clk;

    config_shift_master dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .STATCNF_IN(stat), .DYNCNF_IN(dyn),
        .BUSY(busy), .DONE(done), .SCLK(sclk), .SEL(sel), .SDI(sdi), .SDO(sdo),
        .RDBK(rdbk), .MISMATCH(mism)
    );

    config_shift_master #(.CLKDIV(6)) dut6 (
        .CLK(clk), .RST_N(rst_n), .START(start6), .STATCNF_IN(stat), .DYNCNF_IN(dyn),
        .BUSY(busy6), .DONE(done6), .SCLK(sclk6), .SEL(sel6), .SDI(sdi6), .SDO(1'b0),
        .RDBK(rdbk6), .MISMATCH(mism6)
    );

    // Chain model: shift register clocked by SCLK, tail drives SDO.
    always @(posedge sclk or posedge flip_stb or negedge rst_n) begin
        if (!rst_n)        chain <= '0;
        else if (flip_stb) chain <= chain ^ flip_mask;
        else               chain <= {chain[FL-2:0], sdi};
    end
    assign sdo = chain[FL-1];

    always @(negedge sel or negedge rst_n) begin
        if (!rst_n) latched <= '0;
        else        latched <= chain;
    end

    always @(posedge sclk) sclk_rises <= sclk_rises + 1;
    always @(posedge done) done_rises <= done_rises + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic flip_chain_bit(input int unsigned b);
        flip_mask    = '0;
        flip_mask[b] = 1'b1;
        flip_stb     = 1'b1;
        #1;
        flip_stb     = 1'b0;
        exp_chain[b] = ~exp_chain[b];
    endtask

    task automatic run_xfer(input logic [87:0] s, input logic [15:0] d, input bit noise);
        logic [FL-1:0] frame;
        logic [FL-1:0] exp_rdbk;
        logic          exp_mism;
        int unsigned   cyc, r0, d0;
        frame    = {s, d};
        exp_rdbk = exp_chain;
        exp_mism = (exp_chain != exp_prev);
        @(negedge clk);
        stat  = s;
        dyn   = d;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        r0  = sclk_rises;
        d0  = done_rises;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (noise && (cyc == 10 || cyc == 200 || cyc == 840)) begin
                start = 1'b1;
                stat  = 88'({$urandom(), $urandom(), $urandom()});
                dyn   = 16'($urandom());
            end else begin
                start = 1'b0;
            end
            if (cyc == 420) begin
                check_eq("busy_mid", 128'(busy), 128'(1));
                check_eq("sel_mid", 128'(sel), 128'(1));
                check_eq("rdbk_hold", 128'(rdbk), 128'(exp_last_rdbk));
                check_eq("mism_hold", 128'(mism), 128'(exp_last_mism));
            end
        end
        start = 1'b0;
        check_eq("latency", 128'(cyc), 128'(841));
        check_eq("sclk_rises", 128'(sclk_rises - r0), 128'(FL));
        check_eq("rdbk", 128'(rdbk), 128'(exp_rdbk));
        check_eq("mismatch", 128'(mism), 128'(exp_mism));
        check_eq("chain_latched", 128'(latched), 128'(frame));
        check_eq("busy_at_done", 128'(busy), 128'(1));
        exp_chain     = frame;
        exp_prev      = frame;
        exp_last_rdbk = exp_rdbk;
        exp_last_mism = exp_mism;
        repeat (3) @(negedge clk);
        check_eq("done_pulses", 128'(done_rises - d0), 128'(1));
        check_eq("busy_after", 128'(busy), 128'(0));
    endtask

    logic [FL-1:0] frame_bb;
    int unsigned   cyc, r0, d0, last_rise, last_chg, rises, bad;
    logic          prev_s, prev_sdi, have_rise;

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", 128'({busy, done, sclk, sel, sdi, mism}), '0);
        check_eq("reset_rdbk", 128'(rdbk), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_ctrl", 128'({busy, done, sclk, sel, sdi, mism, busy6, sel6}), '0);

        // Directed frames; the first carries ignored START pulses and input churn.
        run_xfer(88'h0, 16'hA5C3, 1'b1);
        check_eq("dyn_latched", 128'(latched[15:0]), 128'(16'hA5C3));
        run_xfer(88'h1, 16'hFFFF, 1'b0);
        flip_chain_bit(50);
        run_xfer(88'({$urandom(), $urandom(), $urandom()}), 16'($urandom()), 1'b0);

        // Randomized frames with occasional returned-bit corruption.
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(1, 0) == 1) flip_chain_bit($urandom_range(FL - 1, 0));
            run_xfer(88'({$urandom(), $urandom(), $urandom()}), 16'($urandom()), 1'b0);
        end

        // START held high: next transfer accepted in the IDLE cycle after DONE.
        frame_bb = {88'({$urandom(), $urandom(), $urandom()}), 16'($urandom())};
        @(negedge clk);
        stat  = frame_bb[FL-1:16];
        dyn   = frame_bb[15:0];
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("held_latency1", 128'(cyc), 128'(841));
        check_eq("held_rdbk1", 128'(rdbk), 128'(exp_chain));
        check_eq("held_mism1", 128'(mism), 128'(exp_chain != exp_prev));
        exp_chain = frame_bb;
        exp_prev  = frame_bb;
        cyc = 0;
        while (!(done === 1'b1 && cyc > 1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq("held_latency2", 128'(cyc), 128'(842));
        check_eq("held_rdbk2", 128'(rdbk), 128'(frame_bb));
        check_eq("held_mism2", 128'(mism), 128'(0));
        check_eq("held_latched", 128'(latched), 128'(frame_bb));
        exp_last_rdbk = frame_bb;
        exp_last_mism = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("held_busy_after", 128'(busy), 128'(0));

        // Asynchronous reset at bit 60 of a transfer.
        @(negedge clk);
        stat  = 88'({$urandom(), $urandom(), $urandom()});
        dyn   = 16'($urandom());
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        r0  = sclk_rises;
        d0  = done_rises;
        cyc = 0;
        while ((sclk_rises - r0) < 60 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_reached_bit60", 128'(sclk_rises - r0), 128'(60));
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_ctrl", 128'({sel, sclk, sdi, busy, done, mism}), '0);
        check_eq("async_rst_rdbk", 128'(rdbk), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (900) @(negedge clk);
        check_eq("no_done_after_rst", 128'(done_rises - d0), 128'(0));
        check_eq("idle_after_rst", 128'({busy, sel}), '0);
        exp_chain     = '0;
        exp_prev      = '0;
        exp_last_rdbk = '0;
        exp_last_mism = 1'b0;
        run_xfer(88'({$urandom(), $urandom(), $urandom()}), 16'($urandom()), 1'b0);

        // CLKDIV=6 instance: timing of SCLK/SDI and latency.
        @(negedge clk);
        stat   = 88'({$urandom(), $urandom(), $urandom()});
        dyn    = 16'($urandom());
        start6 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start6    = 1'b0;
        cyc       = 0;
        prev_s    = sclk6;
        prev_sdi  = sdi6;
        last_rise = 0;
        last_chg  = 0;
        rises     = 0;
        bad       = 0;
        have_rise = 1'b0;
        while (done6 !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (sclk6 && !prev_s) begin
                if (have_rise && (cyc - last_rise) != 12) bad++;
                if ((cyc - last_chg) < 6) bad++;
                last_rise = cyc;
                have_rise = 1'b1;
                rises++;
            end else if (!sclk6 && prev_s) begin
                if ((cyc - last_rise) != 6) bad++;
                if (last_chg > last_rise) bad++;
            end
            if (sdi6 != prev_sdi) last_chg = cyc;
            prev_s   = sclk6;
            prev_sdi = sdi6;
        end
        check_eq("div6_latency", 128'(cyc), 128'(1261));
        check_eq("div6_rises", 128'(rises), 128'(FL));
        check_eq("div6_timing_violations", 128'(bad), 128'(0));
        check_eq("div6_rdbk", 128'(rdbk6), '0);
        check_eq("div6_mism", 128'(mism6), 128'(0));
        repeat (3) @(negedge clk);
        check_eq("div6_idle", 128'({busy6, sel6}), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
